// File: rtl/sli_seq_ctrl.sv
// Structured-light pattern sequencer: owns frq/fra, ready credits and the camera trigger pulse.
// Define SEQ_LOOP_EN to wrap the sequence forever; otherwise it parks in DONE after the last frame.
module sli_seq_ctrl #(
    parameter int NUM_FRA  = 8,
    parameter int NUM_FRQ  = 4,
    parameter int CRED_W   = 4,
    parameter int TRIG_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vsync,
    input  logic              rdy,
    input  logic              mode,
    input  logic              ori_sel,
    output logic [1:0]        frq,
    output logic [2:0]        fra,
    output logic              ori,
    output logic              hold,
    output logic              trig,
    output logic              f_frm,
    output logic              seq_done,
    output logic [CRED_W-1:0] credits
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0]        FRA_LAST  = 3'(NUM_FRA - 1);
    localparam logic [1:0]        FRQ_LAST  = 2'(NUM_FRQ - 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = {CRED_W{1'b1}};
    localparam logic [CRED_W-1:0] CRED_ZERO = {CRED_W{1'b0}};
    localparam logic [CRED_W-1:0] CRED_ONE  = {{(CRED_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        TRIG_INIT = 8'(TRIG_LEN);

    logic              rst_meta_q, rst_hold_q;
    logic              rdy_s1_q, rdy_s2_q, rdy_s3_q;
    logic              ori_s1_q, ori_s2_q;
    logic              vs_q;
    state_t            state_q, state_d;
    logic [1:0]        frq_q, frq_d;
    logic [2:0]        fra_q, fra_d;
    logic              ori_q, ori_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic [7:0]        trig_cnt_q, trig_cnt_d;
    logic              trig_q, trig_d;
    logic              rdy_rise_s, vs_rise_s, restart_s, adv_s, fire_s;

    assign rdy_rise_s = rdy_s2_q & ~rdy_s3_q;
    assign vs_rise_s  = in_vsync & ~vs_q;

    // Reset release is held off for two clocks so the controller leaves reset synchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_hold_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_hold_q <= rst_meta_q;
        end
    end

    // Input synchronisers and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_s1_q <= 1'b0;
            rdy_s2_q <= 1'b0;
            rdy_s3_q <= 1'b0;
            ori_s1_q <= 1'b0;
            ori_s2_q <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            rdy_s1_q <= rdy;
            rdy_s2_q <= rdy_s1_q;
            rdy_s3_q <= rdy_s2_q;
            ori_s1_q <= ori_sel;
            ori_s2_q <= ori_s1_q;
            vs_q     <= in_vsync;
        end
    end

    // Sequencer next state: indices, orientation, credits and trigger counter.
    always_comb begin
        state_d   = state_q;
        frq_d     = frq_q;
        fra_d     = fra_q;
        ori_d     = ori_q;
        hold_d    = hold_q;
        done_d    = done_q;
        restart_s = 1'b0;
        adv_s     = 1'b0;
        fire_s    = 1'b0;
        case (state_q)
            IDLE: begin
                frq_d  = 2'd0;
                fra_d  = 3'd0;
                hold_d = 1'b1;
                done_d = 1'b0;
                if (vs_rise_s && mode) begin
                    state_d = RUN;
                    ori_d   = ori_s2_q;
                    hold_d  = 1'b0;
                    fire_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, DONE: begin
                if (!vs_rise_s) begin
                    state_d = state_q;
                end else if (!mode) begin
                    state_d = IDLE;
                    frq_d   = 2'd0;
                    fra_d   = 3'd0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                end else if (ori_s2_q != ori_q) begin
                    restart_s = 1'b1;
                    state_d   = RUN;
                    ori_d     = ori_s2_q;
                    frq_d     = 2'd0;
                    fra_d     = 3'd0;
                    hold_d    = 1'b1;
                    done_d    = 1'b0;
                    fire_s    = 1'b1;
                end else if (state_q == DONE) begin
                    state_d = DONE;
                end else if ((credits_q != CRED_ZERO) || rdy_rise_s) begin
                    adv_s  = 1'b1;
                    hold_d = 1'b0;
                    fire_s = 1'b1;
                    if (fra_q != FRA_LAST) begin
                        fra_d = fra_q + 3'd1;
                    end else if (frq_q != FRQ_LAST) begin
                        fra_d = 3'd0;
                        frq_d = frq_q + 2'd1;
                    end else begin
`ifdef SEQ_LOOP_EN
                        fra_d = 3'd0;
                        frq_d = 2'd0;
`else
                        state_d = DONE;
                        hold_d  = 1'b1;
                        done_d  = 1'b1;
                        fire_s  = 1'b0;
`endif
                    end
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                frq_d   = 2'd0;
                fra_d   = 3'd0;
                hold_d  = 1'b1;
                done_d  = 1'b0;
            end
        endcase

        // A ready edge that coincides with an advance is consumed by it, even at zero credits.
        if ((state_q == IDLE) || (state_d == IDLE) || restart_s) begin
            credits_d = CRED_ZERO;
        end else if (adv_s && !rdy_rise_s) begin
            credits_d = credits_q - CRED_ONE;
        end else if (!adv_s && rdy_rise_s && (credits_q != CRED_MAX)) begin
            credits_d = credits_q + CRED_ONE;
        end else begin
            credits_d = credits_q;
        end

        if (!mode || (state_d != RUN)) begin
            trig_cnt_d = 8'd0;
        end else if (fire_s) begin
            trig_cnt_d = TRIG_INIT;
        end else if (trig_cnt_q != 8'd0) begin
            trig_cnt_d = trig_cnt_q - 8'd1;
        end else begin
            trig_cnt_d = 8'd0;
        end
        trig_d = (trig_cnt_d != 8'd0);

        if (rst_hold_q) begin
            state_d    = IDLE;
            frq_d      = 2'd0;
            fra_d      = 3'd0;
            ori_d      = 1'b0;
            hold_d     = 1'b1;
            done_d     = 1'b0;
            credits_d  = CRED_ZERO;
            trig_cnt_d = 8'd0;
            trig_d     = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frq_q      <= 2'd0;
            fra_q      <= 3'd0;
            ori_q      <= 1'b0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            credits_q  <= CRED_ZERO;
            trig_cnt_q <= 8'd0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frq_q      <= frq_d;
            fra_q      <= fra_d;
            ori_q      <= ori_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            credits_q  <= credits_d;
            trig_cnt_q <= trig_cnt_d;
            trig_q     <= trig_d;
        end
    end

    assign frq      = frq_q;
    assign fra      = fra_q;
    assign ori      = ori_q;
    assign hold     = hold_q;
    assign trig     = trig_q;
    assign seq_done = done_q;
    assign credits  = credits_q;
    assign f_frm    = (frq_q == 2'd0) && (fra_q == 3'd0);

endmodule
